// File: rtl/gpu_mem_responder.sv
// Multi-channel memory responder for the gpu valid/ready memory protocol.
// Register-array store with fixed read/write latency and a host preload port.
module gpu_mem_responder #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CHANNELS  = 4,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]                mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]                mem_write_ready,
    input  logic                                   load_en,
    input  logic [ADDR_BITS-1:0]                   load_address,
    input  logic [DATA_BITS-1:0]                   load_data
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int RCW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int WCW   = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DROP} state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [NUM_CHANNELS-1:0]                wr_commit;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] wr_cmt_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wr_cmt_data;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_rd
        state_t               st, st_nx;
        logic [RCW-1:0]       cnt;
        logic [ADDR_BITS-1:0] addr_q;
        logic [ADDR_BITS-1:0] src;
        logic [DATA_BITS-1:0] data_q;

        always_comb begin
            st_nx = st;
            unique case (st)
                IDLE: if (mem_read_valid[c])
                          st_nx = (READ_LATENCY == 1) ? RESP : BUSY;
                BUSY: if (cnt <= RCW'(1)) st_nx = RESP;
                RESP: st_nx = DROP;
                DROP: if (!mem_read_valid[c]) st_nx = IDLE;
                default: st_nx = IDLE;
            endcase
        end

        // With latency 1 the data is fetched straight from the request address.
        assign src = (st == IDLE) ? mem_read_address[c] : addr_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                st     <= IDLE;
                cnt    <= '0;
                addr_q <= '0;
                data_q <= '0;
            end else begin
                st <= st_nx;
                if (st == IDLE && mem_read_valid[c]) begin
                    addr_q <= mem_read_address[c];
                    cnt    <= RCW'(READ_LATENCY - 1);
                end else if (st == BUSY) begin
                    cnt <= cnt - RCW'(1);
                end
                if (st_nx == RESP) data_q <= mem[src];
            end
        end

        assign mem_read_ready[c] = (st == RESP);
        assign mem_read_data[c]  = data_q;
    end

    if (WRITE_ENABLE != 0) begin : g_wr_on
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_wr
            state_t               st, st_nx;
            logic [WCW-1:0]       cnt;
            logic [ADDR_BITS-1:0] addr_q;
            logic [DATA_BITS-1:0] data_q;

            always_comb begin
                st_nx = st;
                unique case (st)
                    IDLE: if (mem_write_valid[c])
                              st_nx = (WRITE_LATENCY == 1) ? RESP : BUSY;
                    BUSY: if (cnt <= WCW'(1)) st_nx = RESP;
                    RESP: st_nx = DROP;
                    DROP: if (!mem_write_valid[c]) st_nx = IDLE;
                    default: st_nx = IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    st     <= IDLE;
                    cnt    <= '0;
                    addr_q <= '0;
                    data_q <= '0;
                end else begin
                    st <= st_nx;
                    if (st == IDLE && mem_write_valid[c]) begin
                        addr_q <= mem_write_address[c];
                        data_q <= mem_write_data[c];
                        cnt    <= WCW'(WRITE_LATENCY - 1);
                    end else if (st == BUSY) begin
                        cnt <= cnt - WCW'(1);
                    end
                end
            end

            assign wr_commit[c]   = !reset && (st_nx == RESP);
            assign wr_cmt_addr[c] = (st == IDLE) ? mem_write_address[c] : addr_q;
            assign wr_cmt_data[c] = (st == IDLE) ? mem_write_data[c] : data_q;
            assign mem_write_ready[c] = (st == RESP);
        end
    end else begin : g_wr_off
        logic unused_wr;
        assign unused_wr       = ^{mem_write_valid, mem_write_address, mem_write_data};
        assign wr_commit       = '0;
        assign wr_cmt_addr     = '0;
        assign wr_cmt_data     = '0;
        assign mem_write_ready = '0;
    end

    // Later assignments win: lowest channel last, load port after all channels.
    always_ff @(posedge clk) begin
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (wr_commit[c]) mem[wr_cmt_addr[c]] <= wr_cmt_data[c];
        end
        if (load_en) mem[load_address] <= load_data;
    end

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Directed bench for gpu_mem_responder: latency, drop handshake, conflicts,
// reset abort and a read-only instance.
module tb_gpu_mem_responder;

    logic clk = 1'b0;
    logic reset;
    logic load_en;
    logic [7:0]  load_address;
    logic [15:0] load_data;

    logic [3:0]       rv, rr, wv, wr;
    logic [3:0][7:0]  ra, wa;
    logic [3:0][15:0] rd_d, wd;

    logic [3:0]       ro_rv, ro_rr, ro_wv, ro_wr;
    logic [3:0][7:0]  ro_ra, ro_wa;
    logic [3:0][15:0] ro_rd, ro_wd;

    int n_assert = 0;
    int n_fail   = 0;
    logic [15:0] got;
    int cnt;

    always #5 clk = ~clk;

    gpu_mem_responder dut (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv), .mem_read_address(ra),
        .mem_read_ready(rr), .mem_read_data(rd_d),
        .mem_write_valid(wv), .mem_write_address(wa),
        .mem_write_data(wd), .mem_write_ready(wr),
        .load_en(load_en), .load_address(load_address), .load_data(load_data)
    );

    gpu_mem_responder #(.WRITE_ENABLE(0)) dut_ro (
        .clk(clk), .reset(reset),
        .mem_read_valid(ro_rv), .mem_read_address(ro_ra),
        .mem_read_ready(ro_rr), .mem_read_data(ro_rd),
        .mem_write_valid(ro_wv), .mem_write_address(ro_wa),
        .mem_write_data(ro_wd), .mem_write_ready(ro_wr),
        .load_en(load_en), .load_address(load_address), .load_data(load_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [7:0] a, input logic [15:0] d);
        load_en = 1'b1;
        load_address = a;
        load_data = d;
        tick;
        load_en = 1'b0;
    endtask

    task automatic rd(input int ch, input logic [7:0] a, output logic [15:0] d);
        int n;
        n = 0;
        rv[ch] = 1'b1;
        ra[ch] = a;
        tick;
        while (!rr[ch] && n < 8) begin
            tick;
            n++;
        end
        chk("rd_ready", 32'(rr[ch]), 32'd1);
        d = rd_d[ch];
        rv[ch] = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        load_en = 1'b0; load_address = '0; load_data = '0;
        rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
        ro_rv = '0; ro_ra = '0; ro_wv = '0; ro_wa = '0; ro_wd = '0;
        tick;
        // preload while still in reset
        ld(8'h10, 16'h1234);
        ld(8'h20, 16'h5555);
        ld(8'h30, 16'h00AA);
        ld(8'h05, 16'h0000);
        tick;
        chk("rst_rready", 32'(rr), 32'h0);
        chk("rst_rdata", 32'(rd_d[0]), 32'h0);
        chk("rst_wready", 32'(wr), 32'h0);
        reset = 1'b0;
        tick;

        // ch0 read: accepted at edge E0, ready in the cycle after E1
        rv[0] = 1'b1; ra[0] = 8'h10;
        tick;
        ra[0] = 8'h20;
        chk("t1_busy", 32'(rr), 32'h0);
        tick;
        chk("t1_ready", 32'(rr), 32'h1);
        chk("t1_data", 32'(rd_d[0]), 32'h1234);
        tick;
        chk("t1_drop", 32'(rr), 32'h0);
        rv[0] = 1'b0;
        tick;
        rv[0] = 1'b1; ra[0] = 8'h10;
        tick;
        tick;
        chk("t1_reaccept", 32'(rr), 32'h1);
        // valid held: no further pulse
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (rr[0]) cnt++;
        end
        chk("hold_nopulse", 32'(cnt), 32'd0);
        rv[0] = 1'b0;
        tick;
        rv[0] = 1'b1;
        tick;
        tick;
        chk("hold_after_drop", 32'(rr), 32'h1);
        rv[0] = 1'b0;
        tick;
        tick;

        // same-cycle write/read of 0x20 returns the old value
        wv[1] = 1'b1; wa[1] = 8'h20; wd[1] = 16'hBEEF;
        rv[2] = 1'b1; ra[2] = 8'h20;
        tick;
        tick;
        chk("t2_wready", 32'(wr), 32'h2);
        chk("t2_rready", 32'(rr), 32'h4);
        chk("t2_old", 32'(rd_d[2]), 32'h5555);
        wv = '0; rv = '0;
        tick;
        tick;
        rd(3, 8'h20, got);
        chk("t2_new", 32'(got), 32'hBEEF);

        // ch0 vs ch3 conflict: lowest channel wins, both complete
        wv[0] = 1'b1; wa[0] = 8'h05; wd[0] = 16'h1111;
        wv[3] = 1'b1; wa[3] = 8'h05; wd[3] = 16'h3333;
        tick;
        tick;
        chk("t3_wready", 32'(wr), 32'h9);
        wv = '0;
        tick;
        tick;
        rd(1, 8'h05, got);
        chk("t3_winner", 32'(got), 32'h1111);

        // load beats a channel write on the commit edge
        wv[2] = 1'b1; wa[2] = 8'h06; wd[2] = 16'h2222;
        tick;
        load_en = 1'b1; load_address = 8'h06; load_data = 16'h7777;
        tick;
        load_en = 1'b0;
        chk("t4_wready", 32'(wr), 32'h4);
        wv = '0;
        tick;
        tick;
        rd(0, 8'h06, got);
        chk("t4_load_wins", 32'(got), 32'h7777);

        // reset one cycle after write acceptance aborts the write
        wv[0] = 1'b1; wa[0] = 8'h30; wd[0] = 16'hDEAD;
        tick;
        reset = 1'b1;
        tick;
        chk("t5_wready", 32'(wr), 32'h0);
        chk("t5_rready", 32'(rr), 32'h0);
        chk("t5_rdata", 32'(rd_d[0]), 32'h0);
        wv = '0;
        reset = 1'b0;
        tick;
        tick;
        chk("t5_wready_late", 32'(wr), 32'h0);
        rd(0, 8'h30, got);
        chk("t5_kept", 32'(got), 32'h00AA);

        // read-only instance: writes ignored, four concurrent reads
        ro_wv = 4'hF;
        ro_wa = {8'h06, 8'h30, 8'h20, 8'h10};
        ro_wd = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (ro_wr != 4'h0) cnt++;
        end
        chk("ro_wready", 32'(cnt), 32'd0);
        ro_wv = '0;
        ro_rv = 4'hF;
        ro_ra = {8'h06, 8'h30, 8'h20, 8'h10};
        tick;
        tick;
        chk("ro_rready", 32'(ro_rr), 32'hF);
        chk("ro_d0", 32'(ro_rd[0]), 32'h1234);
        chk("ro_d1", 32'(ro_rd[1]), 32'h5555);
        chk("ro_d2", 32'(ro_rd[2]), 32'h00AA);
        chk("ro_d3", 32'(ro_rd[3]), 32'h7777);
        ro_rv = '0;
        tick;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
